// File: rtl/cgra_seq_pkg.sv
// Shared opcode/state encodings for the CGRA instruction sequencer.
package cgra_seq_pkg;

    localparam int OPCODE_BITS = 2;

    typedef enum logic [1:0] {
        OP_DATA = 2'b00,
        OP_JUMP = 2'b01,
        OP_LOOP = 2'b10,
        OP_HALT = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    function automatic opcode_e get_opcode(input logic [OPCODE_BITS-1:0] op_bits);
        return opcode_e'(op_bits);
    endfunction

endpackage

// File: rtl/cgra_seq_imem.sv
// Instruction memory: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module cgra_seq_imem #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cgra_instr_sequencer.sv
// Fetch/decode stage: reads imem at pc_count, issues DATA payloads over valid/ready,
// and resolves JUMP/LOOP/HALT by driving the external PC's load/incr strobes.
module cgra_instr_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int C_WIDTH       = 4,
    parameter int C_INSTR_WIDTH = 32,
    parameter int C_LOOP_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clken,
    input  logic                     start,
    input  logic [C_WIDTH-1:0]       start_addr,
    input  logic                     imem_we,
    input  logic [C_WIDTH-1:0]       imem_waddr,
    input  logic [C_INSTR_WIDTH-1:0] imem_wdata,
    input  logic [C_WIDTH-1:0]       pc_count,
    output logic                     pc_load,
    output logic [C_WIDTH-1:0]       pc_load_value,
    output logic                     pc_incr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [C_INSTR_WIDTH-3:0] out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int PW = C_INSTR_WIDTH - OPCODE_BITS;

    state_e                   state, state_nxt;
    logic [C_LOOP_WIDTH-1:0]  loop_cnt, loop_cnt_nxt;
    logic                     loop_armed, loop_armed_nxt;
    logic [C_INSTR_WIDTH-1:0] instr_q;

    opcode_e                  op;
    logic [C_WIDTH-1:0]       tgt;
    logic [C_LOOP_WIDTH-1:0]  cnt;

    // The imem read register doubles as the decoded-instruction register.
    cgra_seq_imem #(
        .AW (C_WIDTH),
        .DW (C_INSTR_WIDTH)
    ) u_imem (
        .clk   (clk),
        .rst   (rst),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .re    (clken && (state == S_FETCH)),
        .raddr (pc_count),
        .rdata (instr_q)
    );

    assign op  = get_opcode(instr_q[C_INSTR_WIDTH-1 -: OPCODE_BITS]);
    assign tgt = instr_q[C_WIDTH-1:0];
    assign cnt = instr_q[C_WIDTH +: C_LOOP_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            loop_cnt   <= '0;
            loop_armed <= 1'b0;
        end else if (clken) begin
            state      <= state_nxt;
            loop_cnt   <= loop_cnt_nxt;
            loop_armed <= loop_armed_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        loop_cnt_nxt   = loop_cnt;
        loop_armed_nxt = loop_armed;
        pc_load        = 1'b0;
        pc_load_value  = '0;
        pc_incr        = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (clken && start) begin
                    pc_load        = 1'b1;
                    pc_load_value  = start_addr;
                    loop_cnt_nxt   = '0;
                    loop_armed_nxt = 1'b0;
                    state_nxt      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (clken) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_DATA: begin
                        // Valid is held even with clken low so the PE handshake never retracts.
                        out_valid = 1'b1;
                        out_data  = instr_q[PW-1:0];
                        if (clken && out_ready) begin
                            pc_incr   = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                    OP_JUMP: begin
                        if (clken) begin
                            pc_load       = 1'b1;
                            pc_load_value = tgt;
                            state_nxt     = S_FETCH;
                        end
                    end
                    OP_LOOP: begin
                        if (clken) begin
                            state_nxt = S_FETCH;
                            if (!loop_armed) begin
                                if (cnt == '0) begin
                                    pc_incr = 1'b1;
                                end else begin
                                    loop_cnt_nxt   = cnt - C_LOOP_WIDTH'(1);
                                    loop_armed_nxt = 1'b1;
                                    pc_load        = 1'b1;
                                    pc_load_value  = tgt;
                                end
                            end else if (loop_cnt == '0) begin
                                loop_armed_nxt = 1'b0;
                                pc_incr        = 1'b1;
                            end else begin
                                loop_cnt_nxt  = loop_cnt - C_LOOP_WIDTH'(1);
                                pc_load       = 1'b1;
                                pc_load_value = tgt;
                            end
                        end
                    end
                    OP_HALT: begin
                        if (clken) begin
                            state_nxt = S_HALTED;
                        end
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_FETCH) || (state == S_EXEC);
    assign done = (state == S_HALTED);

endmodule
